// File: rtl/store_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// store_buffer_ctrl
//
// Store buffer and drain controller sitting between the MEM stage and the
// data-memory write port. Committed stores are converted into word-aligned
// writes with byte enables and lane-replicated data, queued in a DEPTH-entry
// FIFO, and drained one at a time over a mem_write/mem_resp handshake. Loads
// that touch the word of any pending store are flagged so the pipeline can
// stall them.
//
// Ports:
//   clk                 clock
//   rst_n               synchronous active-low reset
//   st_valid_i          MEM stage presents a store this cycle
//   st_addr_i           store byte address
//   st_data_i           store data, right-justified
//   st_op_i             00 none, 01 half, 10 byte, 11 word
//   st_ready_o          buffer can accept a store (from registered count only)
//   ld_req_i            a load is being issued this cycle
//   ld_addr_i           load byte address
//   ld_conflict_o       load word matches a pending store
//   mem_port_busy_i     load path owns the memory port this cycle
//   mem_write_o         write request (registered)
//   mem_address_o       word-aligned write address (registered)
//   mem_wdata_o         write data (registered)
//   mem_byte_enable_o   write lane mask (registered)
//   mem_resp_i          write complete
//   sb_count_o          occupied entries
//   sb_empty_o          sb_count_o == 0
// -----------------------------------------------------------------------------
module store_buffer_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     st_valid_i,
    input  logic [31:0]              st_addr_i,
    input  logic [31:0]              st_data_i,
    input  logic [1:0]               st_op_i,
    output logic                     st_ready_o,

    input  logic                     ld_req_i,
    input  logic [31:0]              ld_addr_i,
    output logic                     ld_conflict_o,

    input  logic                     mem_port_busy_i,
    output logic                     mem_write_o,
    output logic [31:0]              mem_address_o,
    output logic [31:0]              mem_wdata_o,
    output logic [3:0]               mem_byte_enable_o,
    input  logic                     mem_resp_i,

    output logic [$clog2(DEPTH):0]   sb_count_o,
    output logic                     sb_empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StWrite
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Only the word address is kept; the byte offset is folded into the enables.
    logic [29:0]     waddr_q [DEPTH];
    logic [31:0]     data_q  [DEPTH];
    logic [3:0]      be_q    [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    state_e          state_q;
    logic            mem_write_q;
    logic [31:0]     mem_address_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_be_q;

    logic            push;
    logic            pop;
    logic            empty;

    logic [3:0]      enc_be;
    logic [31:0]     enc_data;

    logic [PtrW-1:0] offs;
    logic            hit;

    // Low address bits of a load never affect the word match.
    logic            unused_ld_addr;
    assign unused_ld_addr = ^ld_addr_i[1:0];

    // -------------------------------------------------------------------------
    // Store encoding: byte enables and lane-replicated data
    // -------------------------------------------------------------------------
    always_comb begin
        enc_be   = 4'b0000;
        enc_data = st_data_i;
        unique case (st_op_i)
            2'b01: begin
                // Half: addr[0] is ignored, addr[1] selects the upper half.
                enc_be   = st_addr_i[1] ? 4'b1100 : 4'b0011;
                enc_data = {2{st_data_i[15:0]}};
            end
            2'b10: begin
                enc_be   = 4'b0001 << st_addr_i[1:0];
                enc_data = {4{st_data_i[7:0]}};
            end
            2'b11: begin
                enc_be   = 4'b1111;
                enc_data = st_data_i;
            end
            default: begin
                enc_be   = 4'b0000;
                enc_data = st_data_i;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    assign empty      = (count_q == '0);
    // Deliberately from the registered count: a same-cycle pop does not free a slot.
    assign st_ready_o = (count_q != CntW'(DEPTH));
    assign push       = st_valid_i & st_ready_o & (st_op_i != 2'b00);
    assign pop        = (state_q == StWrite) & mem_resp_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_q[wr_ptr_q] <= st_addr_i[31:2];
            data_q[wr_ptr_q]  <= enc_data;
            be_q[wr_ptr_q]    <= enc_be;
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM with registered memory-port outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // mem_resp_i is ignored here; nothing is outstanding.
                    if (!empty && !mem_port_busy_i) begin
                        state_q       <= StWrite;
                        mem_write_q   <= 1'b1;
                        mem_address_q <= {waddr_q[rd_ptr_q], 2'b00};
                        mem_wdata_q   <= data_q[rd_ptr_q];
                        mem_be_q      <= be_q[rd_ptr_q];
                    end
                end
                StWrite: begin
                    // Outputs hold until the response; port-busy is not consulted.
                    if (mem_resp_i) begin
                        state_q     <= StIdle;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_write_o       = mem_write_q;
    assign mem_address_o     = mem_address_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_byte_enable_o = mem_be_q;

    // -------------------------------------------------------------------------
    // Load conflict: compare against every valid entry, head included
    // -------------------------------------------------------------------------
    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Entry i is valid when its distance from the head is below the count.
            offs = PtrW'(i) - rd_ptr_q;
            if ((CntW'(offs) < count_q) && (waddr_q[i] == ld_addr_i[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_conflict_o = ld_req_i & hit;

    assign sb_count_o = count_q;
    assign sb_empty_o = empty;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
module tb_store_buffer_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_port_busy;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [2:0]  sb_count;
    logic        sb_empty;

    always #5 clk = ~clk;

    store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .st_valid_i        (st_valid),
        .st_addr_i         (st_addr),
        .st_data_i         (st_data),
        .st_op_i           (st_op),
        .st_ready_o        (st_ready),
        .ld_req_i          (ld_req),
        .ld_addr_i         (ld_addr),
        .ld_conflict_o     (ld_conflict),
        .mem_port_busy_i   (mem_port_busy),
        .mem_write_o       (mem_write),
        .mem_address_o     (mem_address),
        .mem_wdata_o       (mem_wdata),
        .mem_byte_enable_o (mem_byte_enable),
        .mem_resp_i        (mem_resp),
        .sb_count_o        (sb_count),
        .sb_empty_o        (sb_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] op, input logic lr,
                         input logic [31:0] la, input logic b, input logic rs);
        rst_n         = r;
        st_valid      = v;
        st_addr       = a;
        st_data       = d;
        st_op         = op;
        ld_req        = lr;
        ld_addr       = la;
        mem_port_busy = b;
        mem_resp      = rs;
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, expected combinational
    // outputs before the edge and registered outputs after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic        r, v;
        logic [31:0] a, d;
        logic [1:0]  op;
        logic        lr;
        logic [31:0] la;
        logic        b, rs;
        logic        e_rdy, e_cf, e_mw;
        logic [31:0] e_ma, e_md;
        logic [3:0]  e_be;
        int          e_cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] op, input logic lr, input logic [31:0] la,
                       input logic b, input logic rs, input logic e_rdy, input logic e_cf,
                       input logic e_mw, input logic [31:0] e_ma, input logic [31:0] e_md,
                       input logic [3:0] e_be, input int e_cnt);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.d = d; t.op = op; t.lr = lr; t.la = la;
        t.b = b; t.rs = rs; t.e_rdy = e_rdy; t.e_cf = e_cf; t.e_mw = e_mw;
        t.e_ma = e_ma; t.e_md = e_md; t.e_be = e_be; t.e_cnt = e_cnt;
        vt.push_back(t);
    endtask

    // ------------------------------------------------------------------
    // Reference model: an ordered list of pending writes plus the current
    // port transaction.
    // ------------------------------------------------------------------
    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    bit          m_wr;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_be;

    function automatic ent_t mkent(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] op);
        ent_t e;
        e.wa = a[31:2];
        e.d  = d;
        e.be = 4'hF;
        if (op == 2'b01) begin
            e.be = a[1] ? 4'b1100 : 4'b0011;
            e.d  = {16'h0, d[15:0]} * 32'h0001_0001;
        end else if (op == 2'b10) begin
            e.be = 4'(1 << a[1:0]);
            e.d  = {24'h0, d[7:0]} * 32'h0101_0101;
        end
        return e;
    endfunction

    function automatic bit model_conflict(input logic lr, input logic [31:0] la);
        bit c = 1'b0;
        foreach (q[k]) if (q[k].wa == la[31:2]) c = 1'b1;
        return lr && c;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] op,
                              input logic b, input logic rs);
        bit acc;
        acc = v && (q.size() < DEPTH) && (op != 2'b00);
        if (!r) begin
            q.delete();
            m_wr = 1'b0; m_a = '0; m_d = '0; m_be = '0;
        end else begin
            if (m_wr) begin
                if (rs) begin
                    q.delete(0);
                    m_wr = 1'b0;
                end
            end else if (q.size() != 0 && !b) begin
                m_wr = 1'b1;
                m_a  = {q[0].wa, 2'b00};
                m_d  = q[0].d;
                m_be = q[0].be;
            end
            if (acc) q.push_back(mkent(a, d, op));
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        drive(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        tick;
        tick;
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_byte_enable), 0);
        chk("rst_count", 32'(sb_count), 0);
        chk("rst_empty", 32'(sb_empty), 1);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_conflict", 32'(ld_conflict), 0);

        // ---------------- directed table ----------------
        // byte store 0x1003, response after three write cycles
        add(1, 1, 32'h1003, 32'hAB, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 32'h1001, 0, 0, 1, 1, 1, 32'h1000, 32'hABABABAB, 4'b1000, 1);
        add(1, 0, 0, 0, 0, 1, 32'h1004, 0, 0, 1, 0, 1, 32'h1000, 32'hABABABAB, 4'b1000, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1000, 32'hABABABAB, 4'b1000, 1);
        add(1, 0, 0, 0, 0, 1, 32'h1002, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h1000, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // two half stores, drained in order with the idle gap between them
        add(1, 1, 32'h2002, 32'h1234, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 32'h2000, 32'h1234, 2'b01, 0, 0, 0, 0, 1, 0, 1, 32'h2000, 32'h12341234, 4'b1100, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h2000, 32'h12341234, 4'b0011, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // op 00 is dropped
        add(1, 1, 32'h4000, 32'hFFFF, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // word store held back by a busy port; load conflicts on its word only
        add(1, 1, 32'h3004, 32'hDEADBEEF, 2'b11, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 32'h3006, 1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 32'h3008, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h3004, 32'hDEADBEEF, 4'b1111, 1);
        add(1, 0, 0, 0, 0, 1, 32'h3006, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h3006, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].v, vt[i].a, vt[i].d, vt[i].op, vt[i].lr, vt[i].la,
                  vt[i].b, vt[i].rs);
            #3;
            chk($sformatf("vec%0d_ready", i), 32'(st_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_conflict", i), 32'(ld_conflict), 32'(vt[i].e_cf));
            tick;
            chk($sformatf("vec%0d_mem_write", i), 32'(mem_write), 32'(vt[i].e_mw));
            chk($sformatf("vec%0d_count", i), 32'(sb_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_empty", i), 32'(sb_empty), 32'(vt[i].e_cnt == 0));
            if (vt[i].e_mw) begin
                chk($sformatf("vec%0d_addr", i), mem_address, vt[i].e_ma);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_md);
                chk($sformatf("vec%0d_be", i), 32'(mem_byte_enable), 32'(vt[i].e_be));
            end
        end

        // ---------------- fill to full, pop does not raise ready ----------------
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h5000 + 32'(4 * k), 32'(k + 1), 2'b11, 0, 0, 0, 0);
            #3;
            chk("fill_ready", 32'(st_ready), 1);
            tick;
            chk("fill_count", 32'(sb_count), 32'(k + 1));
        end
        chk("fill_mem_write", 32'(mem_write), 1);
        chk("fill_head_addr", mem_address, 32'h5000);
        chk("fill_head_data", mem_wdata, 32'h1);
        drive(1, 1, 32'h6000, 32'h99, 2'b11, 0, 0, 0, 0);
        #3;
        chk("full_ready", 32'(st_ready), 0);
        tick;
        chk("full_reject_count", 32'(sb_count), 4);
        drive(1, 1, 32'h6000, 32'h99, 2'b11, 0, 0, 0, 1);
        #3;
        chk("pop_cycle_ready", 32'(st_ready), 0);
        chk("pop_cycle_count", 32'(sb_count), 4);
        tick;
        chk("after_pop_count", 32'(sb_count), 3);
        chk("after_pop_mem_write", 32'(mem_write), 0);
        drive(1, 1, 32'h6000, 32'h99, 2'b11, 0, 0, 0, 0);
        #3;
        chk("refill_ready", 32'(st_ready), 1);
        tick;
        chk("refill_count", 32'(sb_count), 4);
        chk("second_mem_write", 32'(mem_write), 1);
        chk("second_addr", mem_address, 32'h5004);
        chk("second_data", mem_wdata, 32'h2);

        // ---------------- reset in the middle of a write ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("midrst_mem_write", 32'(mem_write), 0);
        chk("midrst_count", 32'(sb_count), 0);
        chk("midrst_empty", 32'(sb_empty), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick;
        chk("idle_resp_ignored", 32'(mem_write), 0);
        chk("idle_resp_count", 32'(sb_count), 0);

        // ---------------- randomized run against the model ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0, 0, 0);
        tick;
        for (int n = 0; n < 2000; n++) begin
            logic        r, v, lr, b, rs;
            logic [31:0] a, d, la;
            logic [1:0]  op;
            r  = ($urandom_range(0, 99) != 0);
            v  = 1'($urandom_range(0, 1));
            a  = 32'h7000 + $urandom_range(0, 15);
            d  = $urandom;
            op = 2'($urandom_range(0, 3));
            lr = 1'($urandom_range(0, 1));
            la = 32'h7000 + $urandom_range(0, 19);
            b  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 2) == 0);
            drive(r, v, a, d, op, lr, la, b, rs);
            #3;
            chk("rnd_ready", 32'(st_ready), 32'(q.size() < DEPTH));
            chk("rnd_conflict", 32'(ld_conflict), 32'(model_conflict(lr, la)));
            chk("rnd_count_pre", 32'(sb_count), 32'(q.size()));
            model_step(r, v, a, d, op, b, rs);
            tick;
            chk("rnd_mem_write", 32'(mem_write), 32'(m_wr));
            chk("rnd_count", 32'(sb_count), 32'(q.size()));
            chk("rnd_empty", 32'(sb_empty), 32'(q.size() == 0));
            if (m_wr) begin
                chk("rnd_addr", mem_address, m_a);
                chk("rnd_wdata", mem_wdata, m_d);
                chk("rnd_be", 32'(mem_byte_enable), 32'(m_be));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
